// File: rtl/freq_count_ctrl.sv
// Frequency counter gate controller: counts synchronised sig_in rises over a fixed
// gate window, converts the count to two BCD digits and strobes load for the display.
module freq_count_ctrl #(
  parameter int UPDATE_PERIOD = 1200,
  parameter int COUNT_W       = 8,
  parameter int PERIOD_W      = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sig_in,
  output logic [3:0] ten_count,
  output logic [3:0] unit_count,
  output logic       load,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COUNT, TENS, LOAD} state_t;

  localparam logic [PERIOD_W-1:0] GATE_LAST = PERIOD_W'(UPDATE_PERIOD - 1);
  localparam logic [COUNT_W-1:0]  TEN       = COUNT_W'(10);
  localparam logic [COUNT_W-1:0]  ONE       = COUNT_W'(1);

  state_t              state;
  logic                s1, s2, s3;
  logic                edge_det;
  logic                edge_sat;
  logic                work_ge10;
  logic [COUNT_W-1:0]  edge_cnt;
  logic [COUNT_W-1:0]  edge_sum;
  logic [COUNT_W-1:0]  work;
  logic [PERIOD_W-1:0] gate_cnt;
  logic [3:0]          tens;

  // s1/s2 resolve metastability; s3 only provides the previous level for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det  = s2 & ~s3;
  assign edge_sat  = &edge_cnt;
  assign edge_sum  = (edge_det && !edge_sat) ? edge_cnt + ONE : edge_cnt;
  assign work_ge10 = (work >= TEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      gate_cnt   <= '0;
      work       <= '0;
      tens       <= '0;
      ten_count  <= '0;
      unit_count <= '0;
      load       <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          gate_cnt <= '0;
          if (enable) begin
            state <= COUNT;
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gate_cnt == GATE_LAST) begin
            // an edge on the final gate cycle still lands in this window
            work  <= edge_sum;
            tens  <= '0;
            state <= TENS;
          end else begin
            gate_cnt <= gate_cnt + PERIOD_W'(1);
            edge_cnt <= edge_sum;
          end
        end
        TENS: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (work_ge10 && tens != 4'd9) begin
            work <= work - TEN;
            tens <= tens + 4'd1;
          end else begin
            state <= LOAD;
            load  <= 1'b1;
            if (work_ge10) begin
              ten_count  <= 4'd9;
              unit_count <= 4'd9;
              overflow   <= 1'b1;
            end else begin
              ten_count  <= tens;
              unit_count <= work[3:0];
              overflow   <= 1'b0;
            end
          end
        end
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_count_ctrl.sv
// Directed bench for freq_count_ctrl: windows with hand-counted edge totals,
// edge timing at window boundaries, async reset and enable abort.
module tb_freq_count_ctrl;

  localparam int UP = 640;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic       sig_in = 1'b0;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       load;
  logic       overflow;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int nl;

  freq_count_ctrl #(
    .UPDATE_PERIOD(UP),
    .COUNT_W      (8),
    .PERIOD_W     (11)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .ten_count (ten_count),
    .unit_count(unit_count),
    .load      (load),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rises at odd cycles 1,3,..,2n-1 of the gate window, plus one optional extra rise.
  function automatic logic pulse_at(input int j, input int n, input int extra);
    return ((j % 2 == 1) && (j < 2 * n)) || (j == extra);
  endfunction

  // Cycle j=1 is the low phase just after the edge that entered COUNT.
  // stop_j>0 returns at that cycle without waiting for load.
  task automatic run_window(input string tag, input int n, input int extra, input int stop_j,
                            input logic [3:0] exp_t, input logic [3:0] exp_u, input logic exp_o);
    int  k;
    bit  got;
    got = 1'b0;
    k   = 0;
    while (busy === 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b1 && k < 2000);
    check({tag, "_start"}, 16'(busy), 16'd1);
    if (busy !== 1'b1) return;
    for (int j = 1; j <= UP + 20 && !got; j++) begin
      if (j > 1) @(negedge clk);
      if (j == stop_j) begin
        sig_in = 1'b0;
        return;
      end
      sig_in = pulse_at(j, n, extra);
      if (load === 1'b1) got = 1'b1;
    end
    sig_in = 1'b0;
    check({tag, "_load"}, 16'(got), 16'd1);
    if (got) begin
      check({tag, "_tens"}, 16'(ten_count), 16'(exp_t));
      check({tag, "_units"}, 16'(unit_count), 16'(exp_u));
      check({tag, "_ovf"}, 16'(overflow), 16'(exp_o));
      @(negedge clk);
      check({tag, "_strobe"}, 16'(load), 16'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sig_in = ~sig_in;
      check("reset_hold", 16'({ten_count, unit_count, load, overflow, busy}), 16'd0);
    end

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_after_reset", 16'(busy), 16'd1);
    enable = 1'b0;
    @(negedge clk);
    check("enable_drop_idle", 16'(busy), 16'd0);
    enable = 1'b1;

    run_window("w37",  37,  0, 0, 4'd3, 4'd7, 1'b0);
    run_window("w0",   0,   0, 0, 4'd0, 4'd0, 1'b0);
    run_window("w10",  10,  0, 0, 4'd1, 4'd0, 1'b0);
    run_window("w99",  99,  0, 0, 4'd9, 4'd9, 1'b0);
    run_window("w150", 150, 0, 0, 4'd9, 4'd9, 1'b1);
    run_window("w5a",  5,   0, 0, 4'd0, 4'd5, 1'b0);
    run_window("w300", 300, 0, 0, 4'd9, 4'd9, 1'b1);

    // Reset asserted while the saturated count is being divided.
    run_window("sat_reset", 300, 0, UP + 3, 4'd0, 4'd0, 1'b0);
    #1 reset = 1'b0;
    #1 check("reset_async", 16'({ten_count, unit_count, load, overflow, busy}), 16'd0);
    nl = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (load === 1'b1) nl++;
    end
    check("reset_no_load", 16'(nl), 16'd0);
    reset = 1'b1;

    run_window("w5b",       5, 0,      0, 4'd0, 4'd5, 1'b0);
    run_window("last_edge", 0, UP - 2, 0, 4'd0, 4'd1, 1'b0);
    run_window("tens_edge", 0, UP - 1, 0, 4'd0, 4'd0, 1'b0);
    run_window("idle_edge", 0, UP + 1, 0, 4'd0, 4'd0, 1'b0);
    run_window("after_idle", 0, 0,     0, 4'd0, 4'd0, 1'b0);

    // Enable dropped mid-COUNT: no load, previous digits held.
    run_window("w37b",  37, 0, 0,   4'd3, 4'd7, 1'b0);
    run_window("abort", 20, 0, 100, 4'd0, 4'd0, 1'b0);
    enable = 1'b0;
    nl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (load === 1'b1) nl++;
    end
    check("abort_no_load", 16'(nl), 16'd0);
    check("abort_tens", 16'(ten_count), 16'd3);
    check("abort_units", 16'(unit_count), 16'd7);
    check("abort_busy", 16'(busy), 16'd0);
    enable = 1'b1;
    run_window("after_abort", 5, 0, 0, 4'd0, 4'd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
